// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: select encodings,
// channel geometry and the default transfer-counter width.
package demux_pkg;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

    // One-hot decode of a destination select.
    function automatic logic [NUM_CH-1:0] sel_dec(input logic [1:0] sel);
        logic [NUM_CH-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry output holding slot: data register plus valid flag.
// A load in the same cycle as a drain wins, so a slot can take one word per
// cycle. With DEMUX_CNT_EN defined the slot also counts completed transfers.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
`ifdef DEMUX_CNT_EN
    ,parameter int CNT_W   = CNT_W_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_W_P-1:0] load_data,
    input  logic                out_ready,
    output logic [DATA_W_P-1:0] out_data,
    output logic                out_valid
`ifdef DEMUX_CNT_EN
    ,input  logic               cnt_clr
    ,output logic [CNT_W-1:0]   cnt
`endif
);

    logic drain;

    assign drain = out_valid & out_ready;

    // Slot state: load has priority over drain; data is kept after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    // Transfer counter: clear beats increment, natural wrap at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_4bit_1to4.sv
// 1-to-4 demultiplexer with a one-word holding slot per channel and
// per-channel valid/ready handshakes. A stalled channel only back-pressures
// words addressed to it.
// Optional feature: define DEMUX_CNT_EN to add per-channel transfer counters
// (cnt_a..cnt_d) and their synchronous clear (cnt_clr).
module demux_4bit_1to4
    import demux_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DATA_W-1:0] out_data_c,
    output logic [DATA_W-1:0] out_data_d,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
`ifdef DEMUX_CNT_EN
    ,input  logic             cnt_clr
    ,output logic [CNT_W-1:0] cnt_a
    ,output logic [CNT_W-1:0] cnt_b
    ,output logic [CNT_W-1:0] cnt_c
    ,output logic [CNT_W-1:0] cnt_d
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [NUM_CH-1:0]             load;
    logic [NUM_CH-1:0][DATA_W-1:0] slot_data;
`ifdef DEMUX_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0]  slot_cnt;
`endif

    // Accept when the addressed slot is empty or emptying this cycle.
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        load     = sel_dec(in_sel) & {NUM_CH{in_valid & in_ready}};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_out_slot #(
            .DATA_W_P (DATA_W)
`ifdef DEMUX_CNT_EN
            ,.CNT_W   (CNT_W)
`endif
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_data  (slot_data[i]),
            .out_valid (out_valid[i])
`ifdef DEMUX_CNT_EN
            ,.cnt_clr  (cnt_clr)
            ,.cnt      (slot_cnt[i])
`endif
        );
    end

    assign out_data_a = slot_data[SEL_A];
    assign out_data_b = slot_data[SEL_B];
    assign out_data_c = slot_data[SEL_C];
    assign out_data_d = slot_data[SEL_D];

`ifdef DEMUX_CNT_EN
    assign cnt_a = slot_cnt[SEL_A];
    assign cnt_b = slot_cnt[SEL_B];
    assign cnt_c = slot_cnt[SEL_C];
    assign cnt_d = slot_cnt[SEL_D];
`endif

endmodule
